// File: rtl/divided_clock_timer.sv
// Down-counting timer that samples a slow divided clock as data, counts its edges and flags expiry.
// Optional build macro TIMER_BOTH_EDGES_EN: count both rising and falling edges of tick_in.
module divided_clock_timer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             overrun,
    output logic             edge_seen
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       reload_q, reload_d;
    logic                   mode_q, mode_d;
    logic                   expired_q, expired_d;
    logic                   overrun_q, overrun_d;
    logic                   edge_seen_q;
    logic                   tick;
    logic                   load_ok;
    logic                   do_load;

`ifdef TIMER_BOTH_EDGES_EN
    assign tick = sync_q[SYNC_STAGES-1] ^ prev_q;
`else
    assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;
`endif

    // A zero load value would expire immediately, so such a start is treated as absent.
    assign load_ok = start && (load_val != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            prev_q      <= 1'b0;
            count_q     <= '0;
            reload_q    <= '0;
            mode_q      <= 1'b0;
            expired_q   <= 1'b0;
            overrun_q   <= 1'b0;
            edge_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev_q      <= sync_q[SYNC_STAGES-1];
            count_q     <= count_d;
            reload_q    <= reload_d;
            mode_q      <= mode_d;
            expired_q   <= expired_d;
            overrun_q   <= overrun_d;
            edge_seen_q <= tick;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        expired_d = expired_q;
        overrun_d = overrun_q;
        do_load   = 1'b0;

        // ack has lowest priority; an expiry below overrides the clear of expired.
        if (ack) begin
            expired_d = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!stop && load_ok) begin
                    do_load = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (load_ok) begin
                    do_load = 1'b1;
                end else if (tick && count_q != '0) begin
                    if (count_q == WIDTH'(1)) begin
                        expired_d = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                            if (expired_q && !ack) begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    if (!stop && load_ok) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            state_d  = RUN;
            count_d  = load_val;
            reload_d = load_val;
            mode_d   = auto_reload;
        end
    end

    always_comb begin
        busy      = (state_q == RUN);
        count     = count_q;
        expired   = expired_q;
        overrun   = overrun_q;
        edge_seen = edge_seen_q;
    end

endmodule

// File: tb/tb_divided_clock_timer.sv
// Directed bench for divided_clock_timer: a vector table plus hand-written multi-cycle corner cases.
module tb_divided_clock_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       start;
    logic       stop;
    logic [7:0] load_val;
    logic       auto_reload;
    logic       ack;
    logic [7:0] count;
    logic       busy;
    logic       expired;
    logic       overrun;
    logic       edge_seen;

    int checks   = 0;
    int failures = 0;

    divided_clock_timer #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
        .load_val(load_val), .auto_reload(auto_reload), .ack(ack),
        .count(count), .busy(busy), .expired(expired), .overrun(overrun),
        .edge_seen(edge_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       ack;
        logic       auto_r;
        logic [7:0] load;
        int         ticks;
        logic [7:0] e_count;
        logic       e_busy;
        logic       e_exp;
        logic       e_ov;
    } vec_t;

    vec_t tbl[22];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full tick_in period of 16 clk cycles (8 high, 8 low).
    task automatic tick_period();
        tick_in = 1'b1;
        cyc(8);
        tick_in = 1'b0;
        cyc(8);
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; start = v.start; stop = v.stop; ack = v.ack;
        auto_reload = v.auto_r; load_val = v.load;
        cyc(1);
        rst = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
        for (int t = 0; t < v.ticks; t++) tick_period();
        chk($sformatf("v%0d_count", idx), count, v.e_count);
        chk($sformatf("v%0d_busy", idx), busy, v.e_busy);
        chk($sformatf("v%0d_expired", idx), expired, v.e_exp);
        chk($sformatf("v%0d_overrun", idx), overrun, v.e_ov);
    endtask

    initial begin
        //            rst  start stop ack  auto load  tk cnt  busy exp  ov
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2, 8'd0,   1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3,   0, 8'd3,   1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd2,   1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd1,   1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd0,   1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd0,   1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   0, 8'd0,   1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd0,   1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2,   0, 8'd2,   1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd1,   1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd2,   1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd1,   1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd2,   1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   0, 8'd2,   1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   0, 8'd2,   1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd2,   1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   0, 8'd2,   1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5,   2, 8'd3,   1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd0,   1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8'd0,   1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 0, 8'd255, 1'b1, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd7,   0, 8'd255, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; tick_in = 1'b0; start = 1'b0; stop = 1'b0;
        load_val = 8'd0; auto_reload = 1'b0; ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick_in = ~tick_in;
            cyc(1);
        end
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_expired", expired, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_edge_seen", edge_seen, 0);
        rst = 1'b0; tick_in = 1'b0;
        cyc(4);

        for (int i = 0; i < 22; i++) apply(tbl[i], i);

        // Tick latency: rise after edge P0 -> count/edge_seen change at edge P3.
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(2);
        start = 1'b1; load_val = 8'd4; auto_reload = 1'b0;
        cyc(1);
        start = 1'b0;
        tick_in = 1'b1;
        cyc(1);
        chk("lat_p1_count", count, 4);
        cyc(1);
        chk("lat_p2_count", count, 4);
        chk("lat_p2_edge", edge_seen, 0);
        cyc(1);
        chk("lat_p3_count", count, 3);
        chk("lat_p3_edge", edge_seen, 1);
        cyc(1);
        chk("lat_p4_edge", edge_seen, 0);
        cyc(4);
        tick_in = 1'b0;
        cyc(8);
        tick_period();
`ifdef TIMER_BOTH_EDGES_EN
        chk("edges_count", count, 0);
        chk("edges_expired", expired, 1);
`else
        chk("edges_count", count, 2);
        chk("edges_expired", expired, 0);
`endif

        // ack coinciding with a periodic expiry: expiry wins, no overrun.
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(2);
        start = 1'b1; load_val = 8'd1; auto_reload = 1'b1;
        cyc(1);
        start = 1'b0;
        tick_period();
        chk("sim_first_expired", expired, 1);
        chk("sim_first_count", count, 1);
        tick_in = 1'b1;
        cyc(2);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        chk("sim_ack_expired", expired, 1);
        chk("sim_ack_overrun", overrun, 0);
        chk("sim_ack_edge", edge_seen, 1);
        cyc(5);
        tick_in = 1'b0;
        cyc(8);
        tick_period();
        chk("sim_third_overrun", overrun, 1);
        chk("sim_third_busy", busy, 1);

        // start coincident with a tick in RUN: the tick is discarded.
        start = 1'b1; load_val = 8'd3; auto_reload = 1'b0; ack = 1'b1;
        cyc(1);
        start = 1'b0; ack = 1'b0;
        chk("restart_count", count, 3);
        tick_in = 1'b1;
        cyc(2);
        start = 1'b1; load_val = 8'd5;
        cyc(1);
        start = 1'b0;
        chk("coinc_count", count, 5);
        chk("coinc_busy", busy, 1);
        cyc(5);
        tick_in = 1'b0;
        cyc(8);
        chk("coinc_hold_count", count, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
